// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one-outstanding imem handshake, 1-entry skid buffer, IF/ID register; grant->IF/ID valid 2 cycles.
// Back-pressure: Stall holds IF/ID, a response arriving under Stall parks in the skid and blocks new requests until drained.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PC,
    output logic        IFID_Valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e      state_q;

    logic [31:0] pc_q,         pc_d;
    logic [31:0] req_pc_q,     req_pc_d;
    logic        skid_vld_q,   skid_vld_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q,    skid_pc_d;
    logic        ifid_vld_q,   ifid_vld_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q,    ifid_pc_d;

    logic        accept;
    logic        rsp_live;
    logic        grant;

    assign accept   = !Stall || !ifid_vld_q;
    assign rsp_live = (state_q == WAIT) && imem_rvalid;

    // Back-to-back issue is only allowed when the returning word has somewhere to go.
    assign imem_req  = rst_n && !Redirect && !skid_vld_q &&
                       ((state_q == IDLE) || (rsp_live && accept));
    assign grant     = imem_req && imem_gnt;
    assign imem_addr = pc_q;

    assign IFID_Instruction = ifid_instr_q;
    assign IFID_PC          = ifid_pc_q;
    assign IFID_Valid       = ifid_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (Redirect) begin
            // A fetch still in flight must have its response swallowed.
            state_q <= (state_q != IDLE && !imem_rvalid) ? DROP : IDLE;
        end else begin
            case (state_q)
                IDLE:    if (grant) state_q <= WAIT;
                WAIT:    if (imem_rvalid) state_q <= grant ? WAIT : IDLE;
                DROP:    if (imem_rvalid) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        ifid_vld_d   = ifid_vld_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;

        if (Redirect) begin
            pc_d         = RedirectPC;
            skid_vld_d   = 1'b0;
            ifid_vld_d   = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else begin
            if (grant) begin
                req_pc_d = pc_q;
                pc_d     = pc_q + 32'd4;
            end

            if (accept) begin
                if (rsp_live) begin
                    ifid_vld_d   = 1'b1;
                    ifid_instr_d = imem_rdata;
                    ifid_pc_d    = req_pc_q;
                end else if (skid_vld_q) begin
                    ifid_vld_d   = 1'b1;
                    ifid_instr_d = skid_instr_q;
                    ifid_pc_d    = skid_pc_q;
                    skid_vld_d   = 1'b0;
                end else begin
                    ifid_vld_d   = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end
            end else if (rsp_live) begin
                skid_vld_d   = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = req_pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            req_pc_q     <= 32'd0;
            skid_vld_q   <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
            ifid_vld_q   <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            skid_vld_q   <= skid_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            ifid_vld_q   <= ifid_vld_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, checked each cycle against a queue-based model.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam logic [31:0] XORK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = 32'd0;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PC;
    logic        IFID_Valid;

    fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .RedirectPC       (RedirectPC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PC          (IFID_PC),
        .IFID_Valid       (IFID_Valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // stimulus knobs (percent probabilities, latency range)
    int unsigned p_gnt = 100, p_stall = 0, p_redir = 0;
    int unsigned lat_min = 1, lat_max = 1;
    logic [31:0] fix_rpc = 32'd0;
    bit          rand_rpc = 0;
    bit          stray = 0;
    logic        want_rst = 1'b0;
    bit          saw20 = 0;

    // memory side
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_due;

    // reference model: next fetch address, outstanding fetch, pending words, IF/ID contents
    logic [31:0] m_pc, m_oaddr;
    int          m_out;          // 0 none, 1 live, 2 squashed
    logic [31:0] m_bi[$];
    logic [31:0] m_bp[$];
    bit          m_ifv;
    logic [31:0] m_ifi, m_ifp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc  = RPC;
        m_out = 0;
        m_bi.delete();
        m_bp.delete();
        m_ifv = 0;
        m_ifi = NOP;
        m_ifp = 32'd0;
        mem_pend = 0;
    endtask

    task automatic compare_and_step();
        bit acc, arr, e_req;
        if (!rst_n) begin
            chk("rst_req", imem_req, 0);
            chk("rst_valid", IFID_Valid, 0);
            chk("rst_instr", IFID_Instruction, NOP);
            chk("rst_ifpc", IFID_PC, 0);
            chk("rst_addr", imem_addr, RPC);
            model_reset();
            return;
        end
        acc   = !Stall || !m_ifv;
        arr   = imem_rvalid && (m_out == 1);
        e_req = !Redirect && (m_bi.size() == 0) && ((m_out == 0) || (arr && acc));

        chk("req", imem_req, e_req);
        chk("addr", imem_addr, m_pc);
        chk("valid", IFID_Valid, m_ifv);
        chk("instr", IFID_Instruction, m_ifv ? m_ifi : NOP);
        if (m_ifv) chk("ifpc", IFID_PC, m_ifp);
        if (IFID_Valid && IFID_PC == 32'h20) saw20 = 1;

        if (imem_rvalid && mem_pend && cyc == mem_due) mem_pend = 0;
        if (imem_req && imem_gnt) begin
            mem_pend = 1;
            mem_addr = imem_addr;
            mem_due  = cyc + int'($urandom_range(lat_max, lat_min));
        end

        if (Redirect) begin
            m_pc  = RedirectPC;
            m_ifv = 0;
            m_bi.delete();
            m_bp.delete();
            m_out = (m_out != 0 && !imem_rvalid) ? 2 : 0;
        end else begin
            if (arr) begin
                m_bi.push_back(m_oaddr ^ XORK);
                m_bp.push_back(m_oaddr);
            end
            if (acc) begin
                if (m_bi.size() != 0) begin
                    m_ifv = 1;
                    m_ifi = m_bi.pop_front();
                    m_ifp = m_bp.pop_front();
                end else begin
                    m_ifv = 0;
                end
            end
            if (m_out != 0 && imem_rvalid) m_out = 0;
            if (e_req && imem_gnt) begin
                m_out   = 1;
                m_oaddr = m_pc;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cycle();
        bit due;
        @(posedge clk);
        #1;
        cyc++;
        rst_n    = want_rst;
        Stall    = ($urandom_range(99) < p_stall);
        Redirect = ($urandom_range(99) < p_redir);
        if (rand_rpc) begin
            case ($urandom_range(7))
                0:       RedirectPC = 32'hFFFF_FFFC;
                1:       RedirectPC = 32'h0000_0000;
                default: RedirectPC = $urandom & 32'h0000_FFFC;
            endcase
        end else begin
            RedirectPC = fix_rpc;
        end
        imem_gnt    = ($urandom_range(99) < p_gnt);
        due         = mem_pend && (cyc == mem_due);
        imem_rvalid = due || stray;
        imem_rdata  = due ? (mem_addr ^ XORK) : $urandom;
        @(negedge clk);
        compare_and_step();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] held;
        bit found;
        model_reset();

        repeat (3) cycle();
        want_rst = 1'b1;

        // zero-wait stream from reset
        cycle();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        cycle();
        chk("b2b_addr", imem_addr, 32'h4);
        cycle();
        chk("lat_valid", IFID_Valid, 1);
        chk("lat_pc0", IFID_PC, 32'h0);
        chk("lat_instr0", IFID_Instruction, 32'hA5A5_0000);
        cycle();
        chk("pc4", IFID_PC, 32'h4);
        cycle();
        chk("pc8", IFID_PC, 32'h8);
        chk("instr8", IFID_Instruction, 32'hA5A5_0008);
        repeat (4) cycle();

        // stall with response in flight -> skid
        p_stall = 100;
        cycle();
        a = IFID_PC;
        chk("stall_req", imem_req, 0);
        repeat (2) begin
            cycle();
            chk("stall_hold", IFID_PC, a);
            chk("stall_req_low", imem_req, 0);
        end
        p_stall = 0;
        cycle();
        chk("release_req", imem_req, 0);
        cycle();
        chk("skid_out_pc", IFID_PC, a + 32'd4);
        chk("skid_out_valid", IFID_Valid, 1);
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, a + 32'd8);

        // redirect while 0x20 outstanding
        lat_min = 3; lat_max = 3;
        p_redir = 100; fix_rpc = 32'h20;
        cycle();
        p_redir = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (imem_req && imem_gnt && imem_addr == 32'h20) found = 1;
        end
        chk("got20_grant", found, 1);
        saw20 = 0;
        p_redir = 100; fix_rpc = 32'h100;
        cycle();
        p_redir = 0;
        cycle();
        chk("drop_valid", IFID_Valid, 0);
        chk("drop_instr", IFID_Instruction, NOP);
        chk("drop_req", imem_req, 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (imem_req) found = 1;
        end
        chk("post_drop_req", found, 1);
        chk("post_drop_addr", imem_addr, 32'h100);
        lat_min = 1; lat_max = 1;
        repeat (6) cycle();
        chk("drop_never20", saw20, 0);

        // redirect + response + stall in the same cycle
        p_stall = 100; p_redir = 100; fix_rpc = 32'h200;
        cycle();
        p_redir = 0;
        cycle();
        chk("rsr_valid", IFID_Valid, 0);
        chk("rsr_req", imem_req, 1);
        chk("rsr_addr", imem_addr, 32'h200);
        p_stall = 0;

        // skid loaded then redirect
        repeat (4) cycle();
        p_stall = 100;
        repeat (2) cycle();
        p_redir = 100; fix_rpc = 32'h280;
        cycle();
        p_redir = 0; p_stall = 0;
        cycle();
        chk("skidflush_valid", IFID_Valid, 0);
        chk("skidflush_addr", imem_addr, 32'h280);
        chk("skidflush_req", imem_req, 1);

        // grant withheld
        p_gnt = 0;
        cycle();
        held = imem_addr;
        chk("nognt_req0", imem_req, 1);
        repeat (3) begin
            cycle();
            chk("nognt_req", imem_req, 1);
            chk("nognt_addr", imem_addr, held);
        end
        p_redir = 100; fix_rpc = 32'h300;
        cycle();
        chk("withdraw_req", imem_req, 0);
        p_redir = 0;
        cycle();
        chk("withdraw_addr", imem_addr, 32'h300);
        p_gnt = 100;

        // wrap-around
        p_redir = 100; fix_rpc = 32'hFFFF_FFFC;
        cycle();
        p_redir = 0;
        cycle();
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_addr1", imem_addr, 32'h0);
        cycle();
        chk("wrap_ifpc", IFID_PC, 32'hFFFF_FFFC);

        // reset mid-WAIT, then a stray response in IDLE
        want_rst = 1'b0;
        cycle();
        chk("midrst_valid", IFID_Valid, 0);
        want_rst = 1'b1; stray = 1; p_gnt = 0;
        cycle();
        chk("rel_req", imem_req, 1);
        chk("rel_addr", imem_addr, RPC);
        stray = 0;
        cycle();
        chk("stray_ignored", IFID_Valid, 0);
        p_gnt = 100;
        repeat (4) cycle();

        // random traffic
        rand_rpc = 1; p_gnt = 70; p_stall = 30; p_redir = 6;
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 4000; i++) begin
            if (i % 997 == 500) begin
                want_rst = 1'b0;
                cycle();
                want_rst = 1'b1;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RISC-V pipeline. It holds the program counter and issues word fetches to instruction memory over a request/grant/response handshake. It also absorbs one response in a skid buffer during back-pressure and drives the IF/ID pipeline register that feeds the decoder (`Instruction`, `PC`). Redirects from jumps and taken branches flush it, and in-flight responses to squashed fetches are discarded.

## Interface
- `RESET_PC`, `32'h0000_0000`: PC value loaded on reset.
- `NOP_INSTR`, `32'h0000_0013`: bubble instruction driven while IF/ID is invalid (`addi x0,x0,0`).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req` output 1: fetch request; held with a stable `imem_addr` until granted.
- `imem_addr` output 32: fetch address, equal to the PC register.
- `imem_gnt` input 1: memory accepts the request this cycle when `imem_req & imem_gnt`.
- `imem_rvalid` input 1: response valid. Responses are in order, at most one outstanding, and arrive no earlier than the cycle after the grant.
- `imem_rdata` input 32: fetched instruction word.
- `Stall` input 1: hazard unit holds IF/ID.
- `Redirect` input 1: jump or taken branch; flushes the stage.
- `RedirectPC` input 32: new fetch address, used when `Redirect` is high.
- `IFID_Instruction` output 32: instruction to the decoder.
- `IFID_PC` output 32: address of `IFID_Instruction`.
- `IFID_Valid` output 1: IF/ID holds a real instruction.

## Operation
- FSM states:
  - IDLE: no outstanding fetch.
  - WAIT: one fetch granted, response pending.
  - DROP: one fetch granted, response to be discarded.
- State registers: `PC` (32), `ReqPC` (address of the outstanding fetch), skid buffer (`SkidValid`, `SkidInstr`, `SkidPC`).
- IF/ID accepts when `accept = !Stall | !IFID_Valid`.
- `imem_req = rst_n & !Redirect & !SkidValid & (state==IDLE | (state==WAIT & imem_rvalid & accept))`. This allows one fetch per cycle when there is no back-pressure.
- On grant: `ReqPC <= PC`, `PC <= PC + 4` (mod 2^32, wraps from `0xFFFF_FFFC` to 0), state becomes WAIT.
- WAIT with `imem_rvalid`:
  - If `accept`: load IF/ID with {`imem_rdata`, `ReqPC`, valid=1}.
  - Otherwise: load the skid buffer.
  - Then go to IDLE, or stay in WAIT if a new grant occurs in the same cycle.
- Skid drain: if `SkidValid & accept`, move the skid contents into IF/ID and clear `SkidValid`. The skid buffer and a response are never both valid, because requests are blocked while `SkidValid`.
- `accept` with nothing to load: IF/ID becomes invalid.
- `Stall` with nothing being loaded: IF/ID holds its contents unchanged.
- Redirect has priority over every other event:
  - `PC <= RedirectPC`.
  - `IFID_Valid <= 0` and `SkidValid <= 0`.
  - Any response arriving in the same cycle is discarded.
  - State: WAIT without `imem_rvalid` goes to DROP; otherwise IDLE.
  - An ungranted request is simply withdrawn (`imem_req` is low during the redirect cycle).
- DROP: a response is discarded on `imem_rvalid`, then the FSM goes to IDLE. No request is issued while in DROP. A Redirect during DROP updates `PC` and stays in DROP.
- `IFID_Instruction` equals `NOP_INSTR` whenever `IFID_Valid` is 0, so the decoder sees no write-enables.
- `RedirectPC` is taken as given. Misalignment checking is the job of the execute stage.

## Timing
- Reset (asynchronous assert, synchronous deassert by the clock domain):
  - `PC = RESET_PC`, state IDLE, `SkidValid = 0`.
  - `IFID_Valid = 0`, `IFID_Instruction = NOP_INSTR`, `IFID_PC = 0`.
  - `imem_req = 0` while `rst_n` is low.
- Latency:
  - Grant at cycle n, response at n+1 (minimum).
  - IF/ID valid at n+2.
  - The first request after reset release is at the first clock with `rst_n` high.
- Throughput: 1 instruction/cycle with a zero-wait memory and no stall.
- Redirect at cycle r: the first request to `RedirectPC` is at r+1 (from IDLE) or after the dropped response (from DROP). No instruction fetched before r reaches IF/ID after r.
- Reset mid-fetch returns to IDLE. A response arriving after reset release with no outstanding fetch is out of protocol; the stage must ignore `imem_rvalid` in IDLE.

## Test plan
- Reset, then zero-wait memory returning `addr ^ 32'hA5A5_0000` with no stall -> requests at 0, 4, 8, …, one per cycle; `IFID_PC` = 0, 4, 8 on consecutive cycles starting 2 cycles after the first grant.
- `Stall` high for 3 cycles while a response arrives -> the response goes to the skid buffer, `imem_req` stays low, IF/ID holds. On stall release, IF/ID shows the skid word and fetching resumes at the next address with no loss or duplication.
- `Redirect` with `RedirectPC = 32'h100` while a fetch of `0x20` is outstanding -> FSM enters DROP, the `0x20` data never reaches IF/ID, `IFID_Valid = 0` with `NOP_INSTR`, and the next request is to `0x100`.
- `Redirect` in the same cycle as `imem_rvalid` and `Stall` -> the response is discarded, the skid buffer is cleared, and the next request is to `RedirectPC`.
- Memory withholding `imem_gnt` for 4 cycles -> `imem_req` and `imem_addr` stay stable throughout; a Redirect during this window withdraws the request and the address changes the next cycle.
- `RedirectPC = 32'hFFFF_FFFC` -> subsequent fetch addresses `0xFFFF_FFFC`, then `0x0000_0000` (wrap). Asserting `rst_n` low mid-WAIT immediately clears `IFID_Valid`, and the first request after release is to `RESET_PC`.
